// File: rtl/dpa_pkg.sv
// Shared constants and helpers for the frame-buffer reader.
// Frame-size codes, pixel counts and the pixel saturation rule live here.
package dpa_pkg;

    localparam logic [1:0] FS_NORMAL = 2'b00;
    localparam logic [1:0] FS_SMALL  = 2'b01;
    localparam logic [1:0] FS_LARGE  = 2'b11;

    localparam int unsigned PIX_SMALL  = 16384;
    localparam int unsigned PIX_NORMAL = 65536;
    localparam int unsigned PIX_LARGE  = 262144;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 19;
    localparam int unsigned PIX_W      = 25;

    // Code 10 is not a real size; it reads as 256x256.
    function automatic logic [CNT_W-1:0] last_index(input logic [1:0] size);
        logic [CNT_W-1:0] n;
        unique case (size)
            FS_SMALL:  n = CNT_W'(PIX_SMALL - 1);
            FS_LARGE:  n = CNT_W'(PIX_LARGE - 1);
            FS_NORMAL: n = CNT_W'(PIX_NORMAL - 1);
            default:   n = CNT_W'(PIX_NORMAL - 1);
        endcase
        return n;
    endfunction

    function automatic logic [7:0] sat8(input logic [9:0] v);
        return (v > 10'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [23:0] pack_rgb(input logic [29:0] q);
        return {sat8(q[29:20]), sat8(q[19:10]), sat8(q[9:0])};
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Small synchronous FIFO holding {last, rgb} pixel words.
// Head word is presented combinationally; push and pop may share a cycle.
module fb_fifo
    import dpa_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned W     = PIX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [2:0]   o_count
);

    logic [W-1:0] r_mem [DEPTH];
    logic [1:0]   r_wptr;
    logic [1:0]   r_rptr;
    logic [2:0]   r_count;
    logic         w_wr;
    logic         w_rd;

    assign o_full  = (r_count == 3'(DEPTH));
    assign o_empty = (r_count == 3'd0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_rd = i_rd && !o_empty;
    assign w_wr = i_wr && (!o_full || w_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 2'd1;
            if (w_rd) r_rptr <= r_rptr + 2'd1;
            if (w_wr && !w_rd)
                r_count <= r_count + 3'd1;
            else if (!w_wr && w_rd)
                r_count <= r_count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer scanner: issues sequential reads for one frame and
// streams saturated 8-bit RGB pixels through a valid/ready port.
module fb_reader
    import dpa_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] fb_base,
    input  logic [1:0]    frame_size,
    output logic [AW-1:0] fb_a,
    output logic          fb_rd,
    input  logic [29:0]   fb_q,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [23:0]   px_data,
    output logic          px_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [AW-1:0]    r_base;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last_idx;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             r_done;

    logic             w_cnt_end;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [2:0]       w_occ;
    logic [PIX_W-1:0] w_head;

    assign w_cnt_end = (r_cnt == r_last_idx);

    // Registered occupancy only, so px_ready never reaches fb_rd.
    assign fb_rd = (r_state == S_RUN)
                && ((w_occ + {2'b00, r_inflight}) <= 3'd2);
    assign fb_a  = r_base + AW'(r_cnt);

    assign px_valid = !w_empty;
    assign px_data  = w_empty ? 24'd0 : w_head[23:0];
    assign px_last  = !w_empty && w_head[24];
    assign w_pop    = px_valid && px_ready;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_cnt           <= '0;
            r_last_idx      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= fb_rd;
            r_inflight_last <= fb_rd && w_cnt_end;
            r_done          <= 1'b0;
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_state    <= S_RUN;
                    r_base     <= fb_base;
                    r_cnt      <= '0;
                    r_last_idx <= last_index(frame_size);
                end
                S_RUN: if (fb_rd) begin
                    if (w_cnt_end) r_state <= S_DRAIN;
                    else           r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_DRAIN: if (w_pop && px_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (r_inflight),
        .i_wdata ({r_inflight_last, pack_rgb(fb_q)}),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assert property (@(posedge clk) disable iff (!reset)
        !(r_inflight && w_full && !w_pop));

endmodule

// File: tb/tb_fb_reader.sv
// Randomised bench for fb_reader against a transaction-count model.
// Covers full frames, stalls, address wrap and mid-frame reset.
module tb_fb_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [19:0] fb_base = '0;
    logic [1:0]  frame_size = 2'b00;
    logic [19:0] fb_a;
    logic        fb_rd;
    logic [29:0] fb_q = '0;
    logic        px_valid;
    logic        px_ready;
    logic [23:0] px_data;
    logic        px_last;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int tb_xfers = 0;
    int frame_xfers = 0;
    int done_cnt = 0;

    fb_reader #(.FIFO_DEPTH(4), .AW(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fb_base    (fb_base),
        .frame_size (frame_size),
        .fb_a       (fb_a),
        .fb_rd      (fb_rd),
        .fb_q       (fb_q),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_last    (px_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] word_at(input logic [19:0] a);
        logic [31:0] h;
        if (a == 20'h00100) return {10'd300, 10'd255, 10'd1023};
        if (a == 20'h00101) return {10'd17, 10'd256, 10'd0};
        h = {12'd0, a} * 32'h9E3779B1;
        return h[31:2];
    endfunction

    function automatic logic [7:0] clip(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic logic [23:0] exp_pix(input logic [19:0] base, input int idx);
        logic [19:0] a;
        logic [29:0] w;
        a = 20'(base + idx);
        w = word_at(a);
        return {clip(int'(w[29:20])), clip(int'(w[19:10])), clip(int'(w[9:0]))};
    endfunction

    function automatic int pix_count(input logic [1:0] sz);
        if (sz == 2'b01) return 16384;
        if (sz == 2'b11) return 262144;
        return 65536;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
            if (n_err > 200) begin
                $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
                $finish;
            end
        end
    endtask

    // Memory: word for the presented address appears one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (fb_rd) fb_q <= word_at(fb_a);
        end
    end

    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      px_ready = 1'b1;
            else if (rdy_mode == 2) px_ready = 1'b0;
            else                    px_ready = 1'($urandom_range(0, 1));
        end
    end

    // Model: counts of reads issued and pixels delivered in the frame.
    initial begin
        bit          m_active = 0;
        bit          m_done = 0;
        logic [19:0] m_base = '0;
        int          m_n = 0;
        int          m_iss = 0;
        int          m_iss_prev = 0;
        int          m_xfer = 0;
        bit          exp_rd;
        bit          xfer;
        bit          accept;
        int          occ;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_fb_rd", fb_rd, 0);
                chk("rst_fb_a", fb_a, 0);
                chk("rst_px_valid", px_valid, 0);
                chk("rst_px_data", px_data, 0);
                chk("rst_px_last", px_last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                m_active = 0;
                m_done = 0;
                m_iss = 0;
                m_iss_prev = 0;
                m_xfer = 0;
                tb_xfers = 0;
            end else begin
                exp_rd = m_active && (m_iss < m_n) && ((m_iss - m_xfer) <= 2);
                occ = m_iss_prev - m_xfer;
                chk("fb_rd", fb_rd, exp_rd);
                if (exp_rd) begin
                    chk("fb_a", fb_a, 20'(m_base + m_iss));
                    if (m_base == 20'h00100 && m_iss == 0)
                        chk("fb_a_first_lit", fb_a, 20'h00100);
                    if (m_base == 20'h00100 && m_iss == 16383)
                        chk("fb_a_last_lit", fb_a, 20'h040FF);
                    if (m_base == 20'hFFFF0 && m_iss == 15)
                        chk("fb_a_pre_wrap_lit", fb_a, 20'hFFFFF);
                    if (m_base == 20'hFFFF0 && m_iss == 16)
                        chk("fb_a_wrap_lit", fb_a, 20'h00000);
                end
                chk("px_valid", px_valid, occ > 0);
                chk("busy", busy, m_active);
                chk("done", done, m_done);
                xfer = (occ > 0) && px_ready;
                if (occ > 0) begin
                    chk("px_data", px_data, exp_pix(m_base, m_xfer));
                    chk("px_last", px_last, m_xfer == m_n - 1);
                    if (xfer && m_base == 20'h00100 && m_xfer == 0)
                        chk("sat_lit0", px_data, 24'hFFFFFF);
                    if (xfer && m_base == 20'h00100 && m_xfer == 1)
                        chk("sat_lit1", px_data, 24'h11FF00);
                end
                if (px_valid && px_ready) tb_xfers++;
                if (done) begin
                    frame_xfers = tb_xfers;
                    tb_xfers = 0;
                    done_cnt++;
                end
                accept = start && !m_active;
                m_done = 0;
                m_iss_prev = m_iss;
                if (exp_rd) m_iss++;
                if (xfer) begin
                    if (m_xfer == m_n - 1) begin
                        m_done = 1;
                        m_active = 0;
                    end
                    m_xfer++;
                end
                if (accept) begin
                    m_active = 1;
                    m_base = fb_base;
                    m_n = pix_count(frame_size);
                    m_iss = 0;
                    m_iss_prev = 0;
                    m_xfer = 0;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        bit ok = 0;
        repeat (budget) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic wait_xfers(input int k, input int budget);
        bit ok = 0;
        repeat (budget) begin
            @(negedge clk);
            #1;
            if (tb_xfers >= k) begin
                ok = 1;
                break;
            end
        end
        chk("xfers_reached", ok, 1);
    endtask

    task automatic pulse_start(input logic [19:0] b, input logic [1:0] sz);
        @(posedge clk);
        #1;
        fb_base = b;
        frame_size = sz;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // 128x128 frame, sink always ready
        rdy_mode = 0;
        done_cnt = 0;
        pulse_start(20'h00100, 2'b01);
        @(negedge clk);
        #1;
        chk("lat_rd_first", fb_rd, 1);
        chk("lat_valid_c1", px_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_valid_c2", px_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_valid_c3", px_valid, 1);
        wait_xfers(16000, 20000);
        // Held start is ignored while busy and taken on the done cycle.
        @(posedge clk);
        #1;
        fb_base = 20'hFFFF0;
        frame_size = 2'b00;
        start = 1'b1;
        wait_done(2000);
        chk("frameA_pixels", frame_xfers, 16384);
        chk("frameA_done_once", done_cnt, 1);
        chk("frameA_busy_low", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        #1;
        chk("restart_on_done", busy, 1);

        // Wrapping 256x256 frame, then reset partway
        wait_xfers(40, 1000);
        do_reset();

        // 512x512 frame reset at pixel 1000
        pulse_start(20'h12345, 2'b11);
        wait_xfers(1000, 5000);
        do_reset();
        @(negedge clk);
        #1;
        chk("post_rst_valid", px_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd", fb_rd, 0);

        // Clean frame with a 20+ cycle sink stall
        done_cnt = 0;
        pulse_start(20'h30000, 2'b01);
        wait_xfers(3000, 8000);
        rdy_mode = 2;
        repeat (21) @(negedge clk);
        #1;
        chk("stall_rd_off", fb_rd, 0);
        chk("stall_valid", px_valid, 1);
        rdy_mode = 1;
        wait_done(60000);
        chk("frameD_pixels", frame_xfers + 3000, 16384 + 3000);
        chk("frameD_done_once", done_cnt, 1);
        @(negedge clk);
        #1;
        chk("frameD_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output-buffer entries; legal value 4 only.
REQ-002 SHALL have parameter AW, default 20, frame-buffer address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle request to scan one frame; ignored while busy=1.
REQ-006 fb_base  input  20  frame start address, sampled on accepted start.
REQ-007 frame_size  input  2  00=256x256, 01=128x128, 11=512x512, 10 treated as 256x256; sampled on accepted start.
REQ-008 fb_a  output  20  frame-buffer read address.
REQ-009 fb_rd  output  1  read strobe; fb_q valid exactly 1 cycle after fb_rd=1.
REQ-010 fb_q  input  30  pixel word {R[29:20],G[19:10],B[9:0]}, 10 bits per channel.
REQ-011 px_valid  output  1  px_data/px_last valid.
REQ-012 px_ready  input  1  sink accepts; transfer when px_valid&px_ready.
REQ-013 px_data  output  24  {R,G,B} 8 bits each.
REQ-014 px_last  output  1  marks final pixel of the frame.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last pixel transfer.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN the cycle after the last read is issued; DRAIN->IDLE when the px_last transfer occurs.
REQ-018 Pixel count N = 16384 / 65536 / 262144 for 128/256/512; 19-bit read counter rd_cnt counts 0..N-1.
REQ-019 fb_a = fb_base + rd_cnt, truncated to 20 bits (wraps modulo 2^20).
REQ-020 In RUN, fb_rd=1 iff fifo_occupancy + inflight <= 2, using registered values only (no combinational path px_ready->fb_rd).
REQ-021 inflight = 1 for the cycle after fb_rd=1, else 0; returned word is written into FIFO that cycle regardless of px_ready.
REQ-022 Each channel saturates: 10-bit value >255 -> 255, else low 8 bits; done before FIFO write.
REQ-023 FIFO stores {last, data} 25 bits; last=1 for the word read at rd_cnt=N-1.
REQ-024 px_valid = FIFO not empty; px_data/px_last driven from FIFO head; head held stable while px_valid&!px_ready.
REQ-025 Simultaneous FIFO write and read SHALL be supported with occupancy unchanged.
REQ-026 With px_ready held 1, throughput SHALL be one pixel per cycle after a 2-cycle start-up (start -> first px_valid = 2 cycles after start accepted... first fb_rd in cycle after start, px_valid 2 cycles after that rd).
REQ-027 FIFO never overflows; write to full FIFO is a design error flagged by assertion.
REQ-028 done asserted the cycle after the px_last transfer; busy falls same cycle as done rises.
REQ-029 start asserted in the same cycle as done is accepted (new frame begins).

Reset
REQ-030 While reset=0: state=IDLE, rd_cnt=0, inflight=0, FIFO empty, fb_rd=0, fb_a=0, px_valid=0, px_data=0, px_last=0, busy=0, done=0.
REQ-031 Reset mid-frame SHALL discard in-flight read data and buffered pixels; no px_valid for 1 cycle after reset release.

Structure
REQ-032 Shared package dpa_pkg SHALL hold frame-size codes (SMALL=01, NORMAL=00, LARGE=11), pixel-count constants, and FIFO_DEPTH.
REQ-033 One sub-module fb_fifo (synchronous 4x25 FIFO, full/empty/occupancy outputs, same clk/reset) SHALL be instantiated.

Verification
REQ-034 start, fb_base=0x00100, size=01, px_ready=1 -> 16384 pixels, fb_a 0x00100..0x040FF, px_last on 16384th, done once, busy low after.
REQ-035 fb_q={10'd300,10'd255,10'd1023} -> px_data=0xFFFFFF; fb_q={10'd17,10'd256,10'd0} -> 0x11FF00.
REQ-036 size=00, px_ready random 50% -> 65536 pixels in address order, no loss/duplication, fb_rd never raised with occupancy+inflight>2.
REQ-037 fb_base=0xFFFF0, size=00 -> fb_a wraps 0xFFFFF->0x00000 at pixel 16.
REQ-038 px_ready=0 for 20 cycles mid-frame -> FIFO fills to 3-4, fb_rd stops, px_data stable; resume with no data loss.
REQ-039 reset=0 at pixel 1000 of size=11 frame -> all outputs at reset values; new start produces a clean full frame from pixel 0.
